mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the single-port data memory
//  (32 x 32-bit words, combinational read, write on posedge clk). Port m0 is
//  the instruction-fetch path, port m1 the load/store path of the MIPS core.
//  Serialises their accesses, drives mem_read/mem_write/address/data_in, and
//  returns registered read data with a one-cycle ack per transaction.
// PARAMETERS
//  DATA_W    32   data width of memory and both requesters
//  ADDR_W    32   byte-address width (word offset = address[6:2])
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  m0_req     in   1       m0 request; hold high with m0_we/addr/wdata until m0_ack
//  m0_we      in   1       1 = write, 0 = read
//  m0_addr    in   ADDR_W  m0 byte address
//  m0_wdata   in   DATA_W  m0 write data
//  m0_ack     out  1       one-cycle pulse, transaction complete
//  m0_err     out  1       one-cycle pulse with m0_ack, access rejected
//  m0_rdata   out  DATA_W  read data, valid when m0_ack=1 and m0_we was 0
//  m1_*       --   --      identical set for requester m1
//  mem_read   out  1       to memory mem_read
//  mem_write  out  1       to memory mem_write
//  mem_addr   out  ADDR_W  to memory address
//  mem_wdata  out  DATA_W  to memory data_in
//  mem_rdata  in   DATA_W  from memory data_out
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE -> ACCESS -> DONE -> IDLE. One transaction per 3 cycles.
//  - IDLE: no req -> stay. Any req -> pick winner, latch its we/addr/wdata into
//    internal regs, set sel, go ACCESS. Only one req -> that one wins.
//  - Both req -> round-robin: winner = requester NOT in last_grant. last_grant
//    updates on every grant. Reset value of last_grant = m1, so m0 wins first tie.
//  - ACCESS, one cycle: mem_addr/mem_wdata = latched values; mem_write = we,
//    mem_read = ~we. The write commits at the closing edge; on a read,
//    mem_rdata is captured into the winner's mN_rdata at the same edge.
//  - DONE: mN_ack=1 for the winner only. mem_read=mem_write=0. Req inputs are
//    ignored in DONE. Next state IDLE.
//  - Latency: req first seen high in IDLE at cycle N -> ACCESS N+1 -> ack N+2.
//    A requester holding req high after ack is re-arbitrated in IDLE (N+3).
//  - Loser's rdata is unchanged. On a write, the winner's rdata is unchanged.
//  - Memory outputs are fully determined by state and latched regs; mem_addr and
//    mem_wdata hold their last latched value outside ACCESS.
//  - mem_read and mem_write are gated with ~reset. Reset asserted during ACCESS:
//    no write commits, no ack, no err; next state is IDLE.
//  - Reset values: state=IDLE, last_grant=m1, all acks/errs=0, mN_rdata=0,
//    mem_read=mem_write=0, latched addr/wdata/we=0, busy=0.
//  - A requester that drops req before ack still completes its latched
//    transaction, and its ack is still pulsed.
// CONFIGURATION
//  MEM_ARB_ALIGN_CHECK_EN defined: a latched address with addr[1:0]!=0, or with
//    addr[ADDR_W-1:7]!=0, still passes through ACCESS. mem_read and
//    mem_write stay 0 in that cycle, and DONE pulses mN_ack together with
//    mN_err=1. rdata is unchanged.
//  Not defined: m0_err=m1_err=0 constantly. Every address is forwarded as is.
// TESTING
//  1 m1 write 0x0000_0010 <- 0xDEAD_BEEF, then m1 read 0x10 -> ack at N+2,
//    mem_write high exactly 1 cycle, m1_rdata=0xDEADBEEF.
//  2 m0 and m1 req in the same cycle after reset, both held -> grants m0, m1,
//    m0, m1; ack every 3 cycles, with no overlap.
//  3 m0 read 0x0 from the init image -> m0_rdata=0x0; m0 read 0x18 -> 0x6;
//    m1_rdata stays 0.
//  4 reset pulsed during ACCESS of m1 write 0x8 <- 0x1234 -> no ack;
//    a later read of 0x8 returns 0x2, the initial value.
//  5 (ALIGN_CHECK_EN) m0 read 0x0000_0006 -> m0_ack and m0_err together;
//    mem_read stays 0. Without the macro -> err=0, word 1 is read.
//  6 m0 drops req in ACCESS -> m0_ack still pulses; busy is 1 for exactly 2 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin sequencer in front of a single-port data memory.
// Optional macro MEM_ARB_ALIGN_CHECK_EN rejects misaligned / out-of-range addresses.
module mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              win;
  logic              addr_bad;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign addr_bad = (addr_q[1:0] != 2'b00) || (addr_q[ADDR_W-1:7] != '0);
`else
  assign addr_bad = 1'b0;
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    win          = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    m0_err       = 1'b0;
    m1_err       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // on a tie the requester not granted last time wins
          win          = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          sel_d        = win;
          last_grant_d = win;
          we_d         = win ? m1_we    : m0_we;
          addr_d       = win ? m1_addr  : m0_addr;
          wdata_d      = win ? m1_wdata : m0_wdata;
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_write = we_q  & ~addr_bad & ~reset;
        mem_read  = ~we_q & ~addr_bad & ~reset;
        if (mem_read) begin
          if (sel_q) m1_rdata_d = mem_rdata;
          else       m0_rdata_d = mem_rdata;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!reset) begin
          m0_ack = ~sel_q;
          m1_ack = sel_q;
          m0_err = ~sel_q & addr_bad;
          m1_err = sel_q & addr_bad;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

endmodule
